// File: rtl/spi_slave_regif.sv
// spi_slave_regif: SPI target oversampled by i_clk, bridging 8-bit command and
// data frames onto a 128x8 register bus.
module spi_slave_regif #(
   parameter int   SYNC_STAGES = 2,
   parameter logic IDLE_MISO   = 1'b0
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_ncs,
   input  logic       i_sclk,
   input  logic       i_mosi,
   output logic       o_miso,
   output logic [6:0] o_reg_addr,
   output logic [7:0] o_reg_wdata,
   output logic       o_reg_we,
   output logic       o_reg_re,
   input  logic [7:0] i_reg_rdata,
   output logic       o_busy,
   output logic       o_abort
);
   typedef enum logic [2:0] {S_IDLE, S_CMD, S_DEC, S_GAP, S_WDATA, S_WR, S_RDATA, S_END} state_t;
   state_t r_state, w_nxt;
   logic [SYNC_STAGES-1:0] r_sclk_s, r_ncs_s, r_mosi_s, r_vld;
   logic       r_sclk_h, r_ncs_h, r_armed;
   logic       w_sclk, w_ncs, w_mosi, w_rise, w_fall, w_ncs_rise, w_ncs_fall;
   logic       w_last, w_abort, w_load, w_shift_in;
   logic [2:0] r_bit_cnt;
   logic [7:0] r_shreg, r_tx_sr, r_wdata;
   logic [6:0] r_addr;
   logic       r_rw, r_re_d, r_we, r_re, r_busy, r_abort;
   assign w_sclk      = r_sclk_s[SYNC_STAGES-1];
   assign w_ncs       = r_ncs_s[SYNC_STAGES-1];
   assign w_mosi      = r_mosi_s[SYNC_STAGES-1];
   assign w_rise      = w_sclk & ~r_sclk_h;
   assign w_fall      = ~w_sclk & r_sclk_h;
   assign w_ncs_rise  = w_ncs & ~r_ncs_h;
   assign w_ncs_fall  = ~w_ncs & r_ncs_h;
   assign w_last      = r_bit_cnt == 3'd0;
   assign w_shift_in  = (r_state == S_CMD || r_state == S_WDATA) && w_rise;
   assign w_load      = w_nxt != r_state && (w_nxt == S_CMD || w_nxt == S_WDATA || w_nxt == S_RDATA);
   assign o_miso      = (r_state == S_RDATA) ? r_tx_sr[7] : IDLE_MISO;
   assign o_reg_addr  = r_addr;
   assign o_reg_wdata = r_wdata;
   assign o_reg_we    = r_we;
   assign o_reg_re    = r_re;
   assign o_busy      = r_busy;
   assign o_abort     = r_abort;
   // r_vld tracks which NCS stages hold real samples rather than the reset preset,
   // so a frame already running at reset release is ignored until NCS is seen high.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sclk_s <= '0;
         r_mosi_s <= '0;
         r_ncs_s  <= '1;
         r_vld    <= '0;
         r_sclk_h <= 1'b0;
         r_ncs_h  <= 1'b1;
         r_armed  <= 1'b0;
      end else begin
         r_sclk_s <= {r_sclk_s[SYNC_STAGES-2:0], i_sclk};
         r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], i_mosi};
         r_ncs_s  <= {r_ncs_s[SYNC_STAGES-2:0], i_ncs};
         r_vld    <= {r_vld[SYNC_STAGES-2:0], 1'b1};
         r_sclk_h <= w_sclk;
         r_ncs_h  <= w_ncs;
         r_armed  <= r_armed | (w_ncs & r_vld[SYNC_STAGES-1]);
      end
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else r_state <= w_nxt;
   end
   // The completing edge is checked before NCS rise so a coincident rise cannot abort.
   always_comb begin
      w_nxt   = r_state;
      w_abort = 1'b0;
      case (r_state)
         S_IDLE: if (w_ncs_fall && r_armed) w_nxt = S_CMD;
         S_CMD, S_WDATA: begin
            if (w_rise && w_last) w_nxt = (r_state == S_CMD) ? S_DEC : S_WR;
            else if (w_ncs_rise) begin
               w_nxt   = S_IDLE;
               w_abort = 1'b1;
            end
         end
         S_DEC: w_nxt = S_GAP;
         S_GAP: if (w_ncs_fall) w_nxt = r_rw ? S_RDATA : S_WDATA;
         S_WR: w_nxt = S_END;
         S_RDATA: begin
            if (w_fall && w_last) w_nxt = S_END;
            else if (w_ncs_rise) begin
               w_nxt   = S_IDLE;
               w_abort = 1'b1;
            end
         end
         S_END: if (w_ncs) w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_bit_cnt <= '0;
         r_shreg   <= '0;
         r_tx_sr   <= '0;
         r_wdata   <= '0;
         r_addr    <= '0;
         r_rw      <= 1'b0;
         r_re_d    <= 1'b0;
         r_we      <= 1'b0;
         r_re      <= 1'b0;
         r_busy    <= 1'b0;
         r_abort   <= 1'b0;
      end else begin
         r_we    <= r_state == S_WR;
         r_re    <= r_state == S_DEC && r_shreg[7];
         r_re_d  <= r_re;
         r_busy  <= w_nxt != S_IDLE;
         r_abort <= w_abort;
         if (w_load) r_bit_cnt <= 3'd7;
         else if (w_shift_in || (r_state == S_RDATA && w_fall)) r_bit_cnt <= r_bit_cnt - 3'd1;
         if (w_shift_in) r_shreg <= {r_shreg[6:0], w_mosi};
         if (r_state == S_DEC) begin
            r_addr <= r_shreg[6:0];
            r_rw   <= r_shreg[7];
         end
         if (r_state == S_WR) r_wdata <= r_shreg;
         // Read data arrives the cycle after the strobe, which is always inside S_GAP.
         if (r_state == S_GAP && r_re_d) r_tx_sr <= i_reg_rdata;
         else if (r_state == S_RDATA && w_fall) r_tx_sr <= {r_tx_sr[6:0], 1'b0};
      end
   end
endmodule

// File: tb/tb_spi_slave_regif.sv
// tb_spi_slave_regif: SPI master model plus register-bus responder with
// queue scoreboards for write and read strobes.
module tb_spi_slave_regif;
   localparam int PH     = 5;
   localparam int GAP    = 6;
   localparam int N_RAND = 100;
   logic       clk = 1'b0, rst_n = 1'b0, ncs = 1'b1, sclk = 1'b0, mosi = 1'b0;
   logic [7:0] rdata = 8'h00;
   logic       miso, we, re, busy, abort_p;
   logic [6:0] addr;
   logic [7:0] wdata;
   int         n_tests = 0, n_fail = 0, n_abort = 0, n_miso_bad = 0;
   logic       rd_win = 1'b0, re_d = 1'b0, busy_seen = 1'b0;
   logic [7:0] periph [128];
   logic [14:0] exp_wr [$];
   logic [6:0]  exp_rd [$];

   spi_slave_regif #(.SYNC_STAGES(3), .IDLE_MISO(1'b0)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_ncs(ncs), .i_sclk(sclk), .i_mosi(mosi),
      .o_miso(miso), .o_reg_addr(addr), .o_reg_wdata(wdata), .o_reg_we(we),
      .o_reg_re(re), .i_reg_rdata(rdata), .o_busy(busy), .o_abort(abort_p)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, got hang, required completion");
      $fatal(1, "timeout");
   end

   // Responder returns data only in the cycle right after the read strobe.
   initial begin : mon
      logic [14:0] e;
      logic [6:0]  ea;
      forever begin
         @(negedge clk);
         rdata = re_d ? periph[addr] : ~periph[addr];
         re_d  = re;
         if (!rd_win && miso !== 1'b0) n_miso_bad++;
         if (abort_p) n_abort++;
         if (we && re) begin
            n_fail++;
            $display("FAIL we_re_overlap: got we=1 re=1, required not both");
         end
         if (we) begin
            n_tests++;
            if (exp_wr.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_we: got addr=%h data=%h, required no write", addr, wdata);
            end else begin
               e = exp_wr.pop_front();
               if ({addr, wdata} !== e) begin
                  n_fail++;
                  $display("FAIL write_bus: got addr=%h data=%h, required addr=%h data=%h", addr, wdata, e[14:8], e[7:0]);
               end
            end
            periph[addr] = wdata;
         end
         if (re) begin
            n_tests++;
            if (exp_rd.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_re: got addr=%h, required no read", addr);
            end else begin
               ea = exp_rd.pop_front();
               if (addr !== ea) begin
                  n_fail++;
                  $display("FAIL read_addr: got %h, required %h", addr, ea);
               end
            end
         end
      end
   end

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic frame(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx  = 8'h00;
      ncs = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         mosi = tx[7-i];
         clks(PH);
         sclk = 1'b1;
         clks(PH);
         rx   = {rx[6:0], miso};
         sclk = 1'b0;
      end
      clks(PH);
      busy_seen = busy;
      ncs = 1'b1;
      clks(GAP);
   endtask

   task automatic do_write(input logic [6:0] a, input logic [7:0] d);
      logic [7:0] rx;
      exp_wr.push_back({a, d});
      frame({1'b0, a}, 8, rx);
      frame(d, 8, rx);
   endtask

   task automatic do_read(input logic [6:0] a, input logic [7:0] exp);
      logic [7:0] rx;
      exp_rd.push_back(a);
      frame({1'b1, a}, 8, rx);
      rd_win = 1'b1;
      frame(8'h00, 8, rx);
      rd_win = 1'b0;
      n_tests++;
      if (rx !== exp) begin
         n_fail++;
         $display("FAIL read_dout addr=%h: got %h, required %h", a, rx, exp);
      end
   endtask

   task automatic check_drained(input string name);
      n_tests++;
      if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drained: got %0d writes %0d reads pending, required 0", name, exp_wr.size(), exp_rd.size());
         exp_wr.delete();
         exp_rd.delete();
      end
   endtask

   task automatic test_reset;
      clks(3);
      n_tests++;
      if ({busy, we, re, abort_p, miso, addr, wdata} !== 20'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h, required 0", {busy, we, re, abort_p, miso, addr, wdata});
      end
      rst_n = 1'b1;
      clks(GAP);
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle_busy: got %b, required 0", busy);
      end
   endtask

   task automatic test_write;
      do_write(7'h15, 8'hA5);
      n_tests++;
      if (busy_seen !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL write_busy: got before_ncs=%b after=%b, required 1 and 0", busy_seen, busy);
      end
      n_tests++;
      if (addr !== 7'h15 || wdata !== 8'hA5) begin
         n_fail++;
         $display("FAIL write_hold: got addr=%h data=%h, required 15 a5", addr, wdata);
      end
      check_drained("write");
   endtask

   task automatic test_read;
      periph[3] = 8'h3C;
      do_read(7'h03, 8'h3C);
      n_tests++;
      if (addr !== 7'h03) begin
         n_fail++;
         $display("FAIL read_hold_addr: got %h, required 03", addr);
      end
      n_tests++;
      if (n_miso_bad != 0) begin
         n_fail++;
         $display("FAIL miso_idle: got %0d cycles nonzero, required 0", n_miso_bad);
      end
      check_drained("read");
   endtask

   task automatic test_back_to_back;
      int ab0;
      ab0 = n_abort;
      periph[0] = 8'h5A;
      do_write(7'h7F, 8'hFF);
      do_read(7'h00, 8'h5A);
      do_write(7'h00, 8'h01);
      n_tests++;
      if (n_abort != ab0) begin
         n_fail++;
         $display("FAIL b2b_abort: got %0d aborts, required 0", n_abort - ab0);
      end
      check_drained("b2b");
   endtask

   task automatic test_abort;
      logic [7:0] rx;
      int ab0;
      ab0 = n_abort;
      frame(8'h40, 8, rx);
      frame(8'hC7, 4, rx);
      n_tests++;
      if (n_abort != ab0 + 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_pulse: got %0d abort cycles busy=%b, required 1 and 0", n_abort - ab0, busy);
      end
      check_drained("abort");
      do_write(7'h02, 8'h11);
      n_tests++;
      if (n_abort != ab0 + 1) begin
         n_fail++;
         $display("FAIL abort_recover: got %0d abort cycles, required 1", n_abort - ab0);
      end
      check_drained("abort_next");
   endtask

   task automatic test_reset_mid;
      logic [7:0] tx;
      int ab0;
      ab0 = n_abort;
      tx  = 8'h55;
      periph[1] = 8'hC3;
      ncs = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mosi = tx[7-i];
         clks(PH);
         sclk = 1'b1;
         clks(PH);
         sclk = 1'b0;
      end
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_pre_busy: got %b, required 1", busy);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({busy, we, re, abort_p, miso, addr, wdata} !== 20'h0) begin
         n_fail++;
         $display("FAIL rst_async: got %h, required 0", {busy, we, re, abort_p, miso, addr, wdata});
      end
      clks(3);
      rst_n = 1'b1;
      for (int i = 3; i < 8; i++) begin
         mosi = tx[7-i];
         clks(PH);
         sclk = 1'b1;
         clks(PH);
         sclk = 1'b0;
      end
      clks(PH);
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_ignore_frame: got busy=%b, required 0", busy);
      end
      ncs = 1'b1;
      clks(GAP);
      n_tests++;
      if (n_abort != ab0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_no_abort: got %0d aborts busy=%b, required 0 and 0", n_abort - ab0, busy);
      end
      do_read(7'h01, 8'hC3);
      check_drained("rst_mid");
   endtask

   task automatic test_random;
      logic [7:0] exp_mem [128];
      logic [6:0] al [N_RAND];
      logic [7:0] d;
      for (int i = 0; i < N_RAND; i++) begin
         al[i] = 7'($urandom_range(0, 127));
         d     = 8'($urandom_range(0, 255));
         exp_mem[al[i]] = d;
         do_write(al[i], d);
      end
      for (int i = 0; i < N_RAND; i++) do_read(al[i], exp_mem[al[i]]);
      check_drained("random");
      n_tests++;
      if (n_miso_bad != 0) begin
         n_fail++;
         $display("FAIL miso_idle_final: got %0d cycles nonzero, required 0", n_miso_bad);
      end
   endtask

   initial begin
      test_reset;
      test_write;
      test_read;
      test_back_to_back;
      test_abort;
      test_reset_mid;
      test_random;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
